conv_encoder_k3: RTL and testbench
==================================

# conv_encoder_k3

Rate-1/2, constraint-length-3 convolutional encoder (generators 7 and 5 octal) that produces the 2-bit coded symbol stream consumed by the Viterbi decoding stage. Sits directly upstream of the decoder: takes a framed serial bit stream, encodes one bit per accepted beat and appends zero-tail termination so every frame ends in trellis state `00`. Registered valid/ready handshake on both sides.

## Interface
- `MAX_FRAME_LEN`, 64: maximum data bits per frame; the counter forces frame end at this length.
- `CNT_W`, 7: bit-counter width; must satisfy 2^CNT_W > MAX_FRAME_LEN.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: upstream bit valid.
- `in_bit` in 1: data bit.
- `in_last` in 1: marks final data bit of frame.
- `in_ready` out 1: encoder accepts a bit this cycle.
- `sym_valid` out 1: coded symbol valid.
- `sym` out 2: `sym[1]`=G0 (111) output, `sym[0]`=G1 (101) output.
- `sym_last` out 1: final symbol of frame (last tail symbol, or last data symbol without tail).
- `sym_ready` in 1: downstream accepts symbol.
- `frame_trunc` out 1: one-cycle pulse, frame forced closed at MAX_FRAME_LEN.
- `busy` out 1: high from first accepted bit until `sym_last` handshake completes.

## Operation
- Shift register `{s1,s0}`, `s0` = previous bit. For input `u`: G0=`u^s0^s1`, G1=`u^s1`; next `{s1,s0}`=`{s0,u}`.
- FSM states: IDLE, DATA, TAIL1, TAIL2.
  - IDLE: `{s1,s0}`=00, counter 0. Accepted bit → DATA (or TAIL1 if `in_last`).
  - DATA: each accept encodes one bit, counter +1. Accept with `in_last`=1, or accept when counter = MAX_FRAME_LEN-1 → TAIL1.
  - TAIL1: when output slot free, encode `u`=0 → TAIL2.
  - TAIL2: when output slot free, encode `u`=0 with `sym_last`=1 → IDLE; counter and shift register end at 0.
- Output slot: one register. Free when `sym_valid`=0 or `sym_ready`=1 (same-cycle refill allowed).
- `in_ready` = state in {IDLE, DATA} AND slot free. Deasserted throughout TAIL1/TAIL2.
- Forced end: counter reaching MAX_FRAME_LEN without `in_last` → that bit treated as last, `frame_trunc` pulses the cycle after acceptance; the next accepted bit starts a new frame.
- `in_last` on the first bit of a frame is legal (1-bit frame, 3 symbols).
- Counter arithmetic: unsigned CNT_W, never wraps (cleared on frame end).
- Reset mid-frame: state IDLE, shift register 00, symbol register emptied; partial frame discarded, no `sym_last` emitted.

## Timing
- Reset values: `sym_valid`=0, `sym`=00, `sym_last`=0, `frame_trunc`=0, `busy`=0; `in_ready`=1 one cycle after `reset_n` release (combinational from state).
- Latency: symbol valid the cycle after its input bit is accepted.
- Throughput: one symbol per cycle with `sym_ready` held high; frame of N bits occupies N+2 symbol beats; next frame's first bit accepted the cycle after the TAIL2 symbol is loaded if slot free.
- `sym`, `sym_last` stable while `sym_valid`=1 and `sym_ready`=0.
- Backpressure: while `sym_ready`=0 and `sym_valid`=1, no state, counter or shift-register change.

## Configuration
- `CONV_ENC_TAIL_EN` defined: zero-tail termination as above (N+2 symbols per frame).
- Not defined: TAIL1/TAIL2 removed; last data symbol carries `sym_last`=1, shift register cleared to 00 on that accept, FSM returns to IDLE (N symbols per frame, truncated trellis).

## Test plan
- Frame 1,0,1,1 (`in_last` on 4th), `sym_ready`=1 → `sym`=11,10,00,01,01,11; `sym_last` only on 6th; `busy` falls after it.
- 1-bit frame `0` with `in_last` → 00,00,00, `sym_last` on 3rd; same with `1` → 11,10,11.
- `sym_ready` low 3 cycles mid-frame → `sym` held, `in_ready`=0, resumed sequence identical to unstalled run.
- 70 bits no `in_last`, MAX_FRAME_LEN=64 → tail after 64th bit, `frame_trunc` one pulse, bits 65-70 encode from state 00 as new frame.
- `reset_n` low after 2 bits of 1,0,1,1 → `sym_valid`=0 immediately; fresh frame 1,0,1,1 reproduces case 1 exactly.
- Without `CONV_ENC_TAIL_EN`: frame 1,0,1,1 → 11,10,00,01, `sym_last` on 4th; next frame starts from state 00.

Source files
------------

// File: rtl/conv_encoder_k3_if.sv
// Handshake bundle for conv_encoder_k3: serial bit input side and 2-bit coded symbol output side.
interface conv_encoder_k3_if;
   logic       in_valid;
   logic       in_bit;
   logic       in_last;
   logic       in_ready;
   logic       sym_valid;
   logic [1:0] sym;
   logic       sym_last;
   logic       sym_ready;
   logic       frame_trunc;
   logic       busy;

   modport master (
      output in_valid, in_bit, in_last, sym_ready,
      input  in_ready, sym_valid, sym, sym_last, frame_trunc, busy
   );

   modport slave (
      input  in_valid, in_bit, in_last, sym_ready,
      output in_ready, sym_valid, sym, sym_last, frame_trunc, busy
   );
endinterface

// File: rtl/conv_encoder_k3.sv
// Rate-1/2, K=3 convolutional encoder (generators 7,5 octal) with framed input and one-deep output slot.
// Define CONV_ENC_TAIL_EN to append two zero-tail symbols per frame so the trellis ends in state 00.
module conv_encoder_k3 #(
   parameter int MAX_FRAME_LEN = 64,
   parameter int CNT_W         = 7
) (
   input  logic             clk,
   input  logic             reset_n,
   conv_encoder_k3_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
`ifdef CONV_ENC_TAIL_EN
      S_DATA  = 2'd1,
      S_TAIL1 = 2'd2,
      S_TAIL2 = 2'd3
`else
      S_DATA  = 2'd1
`endif
   } state_t;

   localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(MAX_FRAME_LEN - 1);

   // G0 = u^s0^s1 (111), G1 = u^s1 (101); s0 is the previous bit
   function automatic logic [1:0] f_encode(input logic u, input logic [1:0] s);
      return {u ^ s[0] ^ s[1], u ^ s[1]};
   endfunction

   state_t           r_state, w_state_nxt;
   logic [1:0]       r_sreg, w_sreg_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_sym_valid;
   logic [1:0]       r_sym;
   logic             r_sym_last;
   logic             r_trunc;
   logic             r_busy;

   logic w_slot_free, w_in_ready, w_accept, w_frame_end;
   logic w_load, w_u, w_last_sym, w_trunc_nxt;

   assign w_slot_free = !r_sym_valid || bus.sym_ready;
   assign w_in_ready  = ((r_state == S_IDLE) || (r_state == S_DATA)) && w_slot_free;
   assign w_accept    = bus.in_valid && w_in_ready;
   assign w_frame_end = bus.in_last || (r_cnt == LP_CNT_LAST);

   always_comb begin
      w_state_nxt = r_state;
      w_sreg_nxt  = r_sreg;
      w_cnt_nxt   = r_cnt;
      w_load      = 1'b0;
      w_u         = 1'b0;
      w_last_sym  = 1'b0;
      w_trunc_nxt = 1'b0;
      case (r_state)
         S_IDLE, S_DATA: begin
            if (w_accept) begin
               w_load     = 1'b1;
               w_u        = bus.in_bit;
               w_sreg_nxt = {r_sreg[0], bus.in_bit};
               if (w_frame_end) begin
                  w_trunc_nxt = !bus.in_last;
                  w_cnt_nxt   = '0;
`ifdef CONV_ENC_TAIL_EN
                  w_state_nxt = S_TAIL1;
`else
                  w_state_nxt = S_IDLE;
                  w_sreg_nxt  = 2'b00;
                  w_last_sym  = 1'b1;
`endif
               end else begin
                  w_cnt_nxt   = r_cnt + 1'b1;
                  w_state_nxt = S_DATA;
               end
            end
         end
`ifdef CONV_ENC_TAIL_EN
         S_TAIL1: begin
            if (w_slot_free) begin
               w_load      = 1'b1;
               w_sreg_nxt  = {r_sreg[0], 1'b0};
               w_state_nxt = S_TAIL2;
            end
         end
         S_TAIL2: begin
            if (w_slot_free) begin
               w_load      = 1'b1;
               w_last_sym  = 1'b1;
               w_sreg_nxt  = 2'b00;
               w_state_nxt = S_IDLE;
            end
         end
`endif
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sreg <= 2'b00;
         r_cnt  <= '0;
      end else begin
         r_sreg <= w_sreg_nxt;
         r_cnt  <= w_cnt_nxt;
      end
   end

   // Output slot: refilled in the same cycle it is drained, held under backpressure
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sym_valid <= 1'b0;
         r_sym       <= 2'b00;
         r_sym_last  <= 1'b0;
         r_trunc     <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         if (w_slot_free) begin
            r_sym_valid <= w_load;
            if (w_load) begin
               r_sym      <= f_encode(w_u, r_sreg);
               r_sym_last <= w_last_sym;
            end
         end
         r_trunc <= w_trunc_nxt;
         if (w_accept)
            r_busy <= 1'b1;
         else if (r_sym_valid && r_sym_last && bus.sym_ready)
            r_busy <= 1'b0;
      end
   end

   assign bus.in_ready    = w_in_ready;
   assign bus.sym_valid   = r_sym_valid;
   assign bus.sym         = r_sym;
   assign bus.sym_last    = r_sym_last;
   assign bus.frame_trunc = r_trunc;
   assign bus.busy        = r_busy;

endmodule

// File: tb/tb_conv_encoder_k3.sv
// Scoreboard bench for conv_encoder_k3: a bit-level encoder model queues expected symbols on each accept.
module tb_conv_encoder_k3;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   conv_encoder_k3_if bus();

   conv_encoder_k3 #(.MAX_FRAME_LEN(64), .CNT_W(7)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int errs = 0;
   int checks = 0;
   logic [2:0] exp_q[$];
   logic [1:0] sym_log[$];
   logic [1:0] ms = 2'b00;
   int mcnt = 0;
   int exp_trunc = 0;
   int trunc_cnt = 0;
   logic hold_v = 1'b0;
   logic [2:0] held = 3'b000;
   logic prev_trunc = 1'b0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, act, want);
      end
   endtask

   // Reference encoder: G0=u^s0^s1, G1=u^s1, state {s1,s0}
   task automatic model_push(input logic b, input logic last);
      logic [1:0] s;
      logic end_f;
      s = {b ^ ms[0] ^ ms[1], b ^ ms[1]};
      end_f = last || (mcnt == 63);
      if (end_f && !last) exp_trunc++;
`ifdef CONV_ENC_TAIL_EN
      exp_q.push_back({s, 1'b0});
      ms = {ms[0], b};
      if (end_f) begin
         exp_q.push_back({ms[0] ^ ms[1], ms[1], 1'b0});
         ms = {ms[0], 1'b0};
         exp_q.push_back({ms[0] ^ ms[1], ms[1], 1'b1});
         ms = 2'b00;
         mcnt = 0;
      end else begin
         mcnt++;
      end
`else
      exp_q.push_back({s, end_f});
      if (end_f) begin
         ms = 2'b00;
         mcnt = 0;
      end else begin
         ms = {ms[0], b};
         mcnt++;
      end
`endif
   endtask

   task automatic send_bit(input logic b, input logic last);
      int n = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_bit   = b;
      bus.in_last  = last;
      #1;
      while (!bus.in_ready && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!bus.in_ready) begin
         chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
         bus.in_valid = 1'b0;
         return;
      end
      model_push(b, last);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      do begin
         @(negedge clk);
         #2;
         n++;
      end while ((exp_q.size() != 0 || bus.sym_valid) && n < 300);
      chk("drain", 32'(exp_q.size() == 0 && !bus.sym_valid), 32'd1);
      chk("busy_idle", 32'(bus.busy), 32'd0);
   endtask

   task automatic check_log(input string tag, input logic [1:0] e[6], input int n);
      chk({tag, "_len"}, 32'(sym_log.size()), 32'(n));
      for (int i = 0; i < n && i < sym_log.size(); i++)
         chk($sformatf("%s_%0d", tag, i), 32'(sym_log[i]), 32'(e[i]));
   endtask

   // Monitor: handshake is committed at the next rising edge
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (!reset_n) begin
            hold_v = 1'b0;
            prev_trunc = 1'b0;
         end else begin
            if (hold_v && bus.sym_valid)
               chk("hold", 32'({bus.sym, bus.sym_last}), 32'(held));
            if (bus.sym_valid && !bus.sym_ready)
               chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            if (bus.frame_trunc) begin
               trunc_cnt++;
               chk("trunc_width", 32'(prev_trunc), 32'd0);
            end
            if (bus.sym_valid && bus.sym_ready) begin
               if (exp_q.size() == 0) begin
                  chk("sb_empty", 32'(exp_q.size()), 32'd1);
               end else begin
                  chk("sym", 32'({bus.sym, bus.sym_last}), 32'(exp_q.pop_front()));
                  sym_log.push_back(bus.sym);
               end
            end
            hold_v = bus.sym_valid && !bus.sym_ready;
            held = {bus.sym, bus.sym_last};
            prev_trunc = bus.frame_trunc;
         end
      end
   end

   initial begin
      logic [1:0] e[6];
      logic [7:0] pat;
      logic b;
      bus.in_valid  = 1'b0;
      bus.in_bit    = 1'b0;
      bus.in_last   = 1'b0;
      bus.sym_ready = 1'b1;

      repeat (3) @(negedge clk);
      #1;
      chk("rst_sym_valid", 32'(bus.sym_valid), 32'd0);
      chk("rst_sym", 32'(bus.sym), 32'd0);
      chk("rst_sym_last", 32'(bus.sym_last), 32'd0);
      chk("rst_trunc", 32'(bus.frame_trunc), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

      // Frame 1,0,1,1
      sym_log.delete();
      send_bit(1'b1, 1'b0);
      chk("busy_frame", 32'(bus.busy), 32'd1);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b1);
      drain();
`ifdef CONV_ENC_TAIL_EN
      e = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
      check_log("f1011", e, 6);
`else
      e = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00};
      check_log("f1011", e, 4);
`endif

      // 1-bit frames
      sym_log.delete();
      send_bit(1'b0, 1'b1);
      drain();
`ifdef CONV_ENC_TAIL_EN
      e = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
      check_log("f0", e, 3);
`else
      e = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
      check_log("f0", e, 1);
`endif
      sym_log.delete();
      send_bit(1'b1, 1'b1);
      drain();
`ifdef CONV_ENC_TAIL_EN
      e = '{2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00};
      check_log("f1", e, 3);
`else
      e = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
      check_log("f1", e, 1);
`endif

      // Downstream stall of 3 cycles mid-frame
      pat = 8'b1101_0011;
      fork
         begin
            for (int i = 0; i < 8; i++) send_bit(pat[i], i == 7);
         end
         begin
            repeat (3) @(negedge clk);
            bus.sym_ready = 1'b0;
            repeat (3) @(negedge clk);
            bus.sym_ready = 1'b1;
         end
      join
      drain();

      // 70 bits without in_last: forced close after bit 64
      for (int i = 0; i < 70; i++) begin
         b = 1'($urandom_range(0, 1));
         send_bit(b, i == 69);
      end
      drain();
      chk("trunc_count", 32'(trunc_cnt), 32'(exp_trunc));
      chk("trunc_expected_one", 32'(exp_trunc), 32'd1);

      // Reset after two bits, then the same frame again from scratch
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_sym_valid", 32'(bus.sym_valid), 32'd0);
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      exp_q.delete();
      ms = 2'b00;
      mcnt = 0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      sym_log.delete();
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b1);
      drain();
`ifdef CONV_ENC_TAIL_EN
      e = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
      check_log("after_rst", e, 6);
`else
      e = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00};
      check_log("after_rst", e, 4);
`endif

      // Back-to-back random frames with random backpressure
      for (int f = 0; f < 3; f++) begin
         fork
            begin
               for (int i = 0; i < 5; i++) begin
                  b = 1'($urandom_range(0, 1));
                  send_bit(b, i == 4);
               end
            end
            begin
               repeat (12) begin
                  @(negedge clk);
                  bus.sym_ready = 1'($urandom_range(0, 1));
               end
               bus.sym_ready = 1'b1;
            end
         join
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
